// File: rtl/decode_pkg.sv
// decode_pkg: opcode/funct constants, ALU control encodings and the control
// bundle shared by the decode stage and its register file.
package decode_pkg;

  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int NUM_REGS  = 32;
  localparam int ALU_CTR_W = 3;

  // Primary opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [ALU_CTR_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_ctr_t;

  // Datapath control carried alongside the decoded instruction
  typedef struct packed {
    logic     reg_dst;
    logic     alu_src;
    logic     mem_write;
    logic     mem_to_reg;
    logic     reg_write;
    logic     ext_op;
    logic     illegal;
    alu_ctr_t alu_ctr;
  } ctrl_t;

  // Sign- or zero-extend a 16-bit immediate to XLEN bits
  function automatic logic [XLEN-1:0] extend_imm(input logic [15:0] imm,
                                                 input logic        sign_ext);
    extend_imm = sign_ext ? {{(XLEN-16){imm[15]}}, imm} : {{(XLEN-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/reg_file_32.sv
// reg_file_32: 32x32 register file, two combinational read ports, one write
// port. $0 always reads zero and ignores writes. Asynchronous active-low reset
// clears every register. Optional macro DECODE_WB_BYPASS_EN forwards same-cycle
// write data to the read ports; without it a read returns the pre-write value.
module reg_file_32
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   rt_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data
);

  logic [XLEN-1:0]   regs_reg [NUM_REGS];
  logic [REG_AW-1:0] rd_addr  [2];
  logic [XLEN-1:0]   rd_data  [2];

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;
  assign rs_data    = rd_data[0];
  assign rt_data    = rd_data[1];

  genvar gi;

  // One storage register per entry; entry 0 is never written so it stays zero
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        regs_reg[gi] <= '0;
      else if (wb_en && (wb_addr != '0) && (wb_addr == REG_AW'(gi)))
        regs_reg[gi] <= wb_data;
    end
  end

  // Read ports: $0 forced to zero, optional same-cycle forwarding of write data
  for (gi = 0; gi < 2; gi++) begin : g_rd
    always_comb begin
      if (rd_addr[gi] == '0)
        rd_data[gi] = '0;
`ifdef DECODE_WB_BYPASS_EN
      else if (wb_en && (wb_addr == rd_addr[gi]))
        rd_data[gi] = wb_data;
`endif
      else
        rd_data[gi] = regs_reg[rd_addr[gi]];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with valid/ready handshake,
// operand read, immediate extension, beq resolution and a writeback port.
// Optional macro DECODE_WB_BYPASS_EN (in reg_file_32) forwards same-cycle
// writeback data to operands read at the acceptance edge.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      rs_data,
  output logic [XLEN-1:0]      rt_data,
  output logic [XLEN-1:0]      ext_imm,
  output logic [REG_AW-1:0]    rw_addr,
  output logic                 reg_dst,
  output logic                 alu_src,
  output logic                 mem_write,
  output logic                 mem_to_reg,
  output logic                 reg_write,
  output logic                 ext_op,
  output logic [ALU_CTR_W-1:0] alu_ctr,
  output logic                 npc_sel,
  output logic                 illegal,
  input  logic                 wb_en,
  input  logic [REG_AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]      wb_data
);

  // Instruction fields
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs_field;
  logic [REG_AW-1:0] rt_field;
  logic [REG_AW-1:0] rd_field;
  logic [15:0]       imm16;

  assign opcode   = instruction[31:26];
  assign rs_field = instruction[25:21];
  assign rt_field = instruction[20:16];
  assign rd_field = instruction[15:11];
  assign funct    = instruction[5:0];
  assign imm16    = instruction[15:0];

  // Operands as seen at the acceptance edge
  logic [XLEN-1:0] rf_rs_data;
  logic [XLEN-1:0] rf_rt_data;

  reg_file_32 u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .rs_addr (rs_field),
    .rt_addr (rt_field),
    .rs_data (rf_rs_data),
    .rt_data (rf_rt_data),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  ctrl_t             ctrl_next;
  logic              is_beq;
  logic              npc_next;
  logic [REG_AW-1:0] rw_addr_next;
  logic [XLEN-1:0]   ext_imm_next;

  // Decoder: control bundle from opcode/funct; illegal encodings never write or branch
  always_comb begin
    ctrl_next         = '0;
    ctrl_next.alu_ctr = ALU_ADD;
    is_beq            = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_next.reg_dst   = 1'b1;
        ctrl_next.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl_next.alu_ctr = ALU_ADD;
          FN_SUB:  ctrl_next.alu_ctr = ALU_SUB;
          FN_AND:  ctrl_next.alu_ctr = ALU_AND;
          FN_OR:   ctrl_next.alu_ctr = ALU_OR;
          FN_SLT:  ctrl_next.alu_ctr = ALU_SLT;
          default: ctrl_next.illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        ctrl_next.alu_src   = 1'b1;
        ctrl_next.reg_write = 1'b1;
        ctrl_next.alu_ctr   = ALU_OR;
      end
      OP_LW: begin
        ctrl_next.alu_src    = 1'b1;
        ctrl_next.mem_to_reg = 1'b1;
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.ext_op     = 1'b1;
      end
      OP_SW: begin
        ctrl_next.alu_src   = 1'b1;
        ctrl_next.mem_write = 1'b1;
        ctrl_next.ext_op    = 1'b1;
      end
      OP_BEQ: begin
        ctrl_next.alu_ctr = ALU_SUB;
        ctrl_next.ext_op  = 1'b1;
        is_beq            = 1'b1;
      end
      default: ctrl_next.illegal = 1'b1;
    endcase
    if (ctrl_next.illegal) begin
      ctrl_next.reg_write = 1'b0;
      ctrl_next.mem_write = 1'b0;
    end
  end

  assign npc_next     = is_beq && !ctrl_next.illegal && (rf_rs_data == rf_rt_data);
  assign rw_addr_next = ctrl_next.reg_dst ? rd_field : rt_field;
  assign ext_imm_next = extend_imm(imm16, ctrl_next.ext_op);

  // Handshake: single output register, accept when empty or being drained
  logic accept;
  logic out_valid_reg;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;

  // Valid flag: set on accept, cleared when consumed without a replacement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_valid_reg <= 1'b0;
    else if (accept)
      out_valid_reg <= 1'b1;
    else if (out_ready)
      out_valid_reg <= 1'b0;
  end

  logic [31:0]       instr_reg;
  logic [XLEN-1:0]   rs_data_reg;
  logic [XLEN-1:0]   rt_data_reg;
  logic [XLEN-1:0]   ext_imm_reg;
  logic [REG_AW-1:0] rw_addr_reg;
  ctrl_t             ctrl_reg;
  logic              npc_reg;

  // Bundle register: captured only on accept, otherwise held (covers stalls)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg   <= RESET_PC_TAG;
      rs_data_reg <= '0;
      rt_data_reg <= '0;
      ext_imm_reg <= '0;
      rw_addr_reg <= '0;
      ctrl_reg    <= '0;
      npc_reg     <= 1'b0;
    end else if (accept) begin
      instr_reg   <= instruction;
      rs_data_reg <= rf_rs_data;
      rt_data_reg <= rf_rt_data;
      ext_imm_reg <= ext_imm_next;
      rw_addr_reg <= rw_addr_next;
      ctrl_reg    <= ctrl_next;
      npc_reg     <= npc_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_instr  = out_valid_reg ? instr_reg : RESET_PC_TAG;
  assign rs_data    = rs_data_reg;
  assign rt_data    = rt_data_reg;
  assign ext_imm    = ext_imm_reg;
  assign rw_addr    = rw_addr_reg;
  assign reg_dst    = ctrl_reg.reg_dst;
  assign alu_src    = ctrl_reg.alu_src;
  assign mem_write  = ctrl_reg.mem_write;
  assign mem_to_reg = ctrl_reg.mem_to_reg;
  assign reg_write  = ctrl_reg.reg_write;
  assign ext_op     = ctrl_reg.ext_op;
  assign alu_ctr    = ctrl_reg.alu_ctr;
  assign illegal    = ctrl_reg.illegal;
  // Branch request to fetch only while the bundle is actually valid
  assign npc_sel    = out_valid_reg && npc_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Expected bundles are
// computed from a reference register-file model when an instruction is
// accepted and compared when execute consumes the bundle.
module tb_decode_stage;

  localparam logic [31:0] TAG = 32'hBAD0_C0DE;

  localparam logic [31:0] I_ADD     = 32'h0109_5020; // add $10,$8,$9
  localparam logic [31:0] I_ORI     = 32'h3404_FFFF; // ori $4,$0,0xFFFF
  localparam logic [31:0] I_LW      = 32'h8C44_FFFC; // lw  $4,-4($2)
  localparam logic [31:0] I_BEQ_EQ  = 32'h1108_0003; // beq $8,$8,+3
  localparam logic [31:0] I_BEQ_NE  = 32'h1109_0003; // beq $8,$9,+3
  localparam logic [31:0] I_SW      = 32'hAD09_0008; // sw  $9,8($8)
  localparam logic [31:0] I_SUB     = 32'h0128_5822; // sub $11,$9,$8
  localparam logic [31:0] I_AND     = 32'h0128_6024; // and $12,$9,$8
  localparam logic [31:0] I_OR      = 32'h0128_6825; // or  $13,$9,$8
  localparam logic [31:0] I_SLT     = 32'h0128_702A; // slt $14,$9,$8
  localparam logic [31:0] I_BADFN   = 32'h0128_703F; // R-type, funct 0x3F
  localparam logic [31:0] I_BADOP   = 32'hFC00_0000; // opcode 0x3F
  localparam logic [31:0] I_ADD_R3  = 32'h0060_2820; // add $5,$3,$0
  localparam logic [31:0] I_ADD_0_3 = 32'h0003_2820; // add $5,$0,$3

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, rs_data, rt_data, ext_imm;
  logic [4:0]  rw_addr;
  logic        reg_dst, alu_src, mem_write, mem_to_reg, reg_write, ext_op;
  logic [2:0]  alu_ctr;
  logic        npc_sel, illegal;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;

  always #5 clk = ~clk;

  decode_stage #(.RESET_PC_TAG(TAG)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .rs_data(rs_data), .rt_data(rt_data), .ext_imm(ext_imm), .rw_addr(rw_addr),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .ext_op(ext_op),
    .alu_ctr(alu_ctr), .npc_sel(npc_sel), .illegal(illegal),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct {
    logic [31:0] instr, rs, rt, imm;
    logic [4:0]  rw;
    logic        reg_dst, alu_src, mem_write, mem_to_reg, reg_write, ext_op;
    logic [2:0]  alu;
    logic        npc, illegal;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mrf [32];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          n_sent = 0;
  int          n_consumed = 0;
  int          cyc = 0;
  bit          rand_mode = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      pass_cnt++;
  endtask

  // Reference register-file read at the acceptance edge
  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_addr == a) return wb_data;
`endif
    return mrf[a];
  endfunction

  // Reference decoder from the instruction-set table
  function automatic exp_t predict(input logic [31:0] ins, input logic [31:0] rsv, input logic [31:0] rtv);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    e = '{instr: ins, rs: rsv, rt: rtv, imm: 32'h0, rw: 5'd0, reg_dst: 1'b0, alu_src: 1'b0,
          mem_write: 1'b0, mem_to_reg: 1'b0, reg_write: 1'b0, ext_op: 1'b0, alu: 3'd0,
          npc: 1'b0, illegal: 1'b0};
    case (op)
      6'h00: begin
        e.reg_dst = 1'b1; e.reg_write = 1'b1;
        case (fn)
          6'h20: e.alu = 3'b000;
          6'h22: e.alu = 3'b001;
          6'h24: e.alu = 3'b010;
          6'h25: e.alu = 3'b011;
          6'h2A: e.alu = 3'b100;
          default: e.illegal = 1'b1;
        endcase
      end
      6'h0D: begin e.alu_src = 1'b1; e.reg_write = 1'b1; e.alu = 3'b011; end
      6'h23: begin e.alu_src = 1'b1; e.mem_to_reg = 1'b1; e.reg_write = 1'b1; e.ext_op = 1'b1; end
      6'h2B: begin e.alu_src = 1'b1; e.mem_write = 1'b1; e.ext_op = 1'b1; end
      6'h04: begin e.alu = 3'b001; e.ext_op = 1'b1; e.npc = (rsv == rtv); end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) begin e.reg_write = 1'b0; e.mem_write = 1'b0; e.npc = 1'b0; end
    e.rw  = e.reg_dst ? ins[15:11] : ins[20:16];
    e.imm = e.ext_op ? {{16{ins[15]}}, ins[15:0]} : {16'h0, ins[15:0]};
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: compare consumed bundles, push accepted ones, track writebacks
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check_eq("spurious_out", {31'b0, out_valid}, 32'h0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          n_consumed++;
          check_eq("out_instr", out_instr, e.instr);
          check_eq("rs_data", rs_data, e.rs);
          check_eq("rt_data", rt_data, e.rt);
          check_eq("ext_imm", ext_imm, e.imm);
          check_eq("rw_addr", {27'b0, rw_addr}, {27'b0, e.rw});
          check_eq("ctrl", {26'b0, reg_dst, alu_src, mem_write, mem_to_reg, reg_write, ext_op},
                   {26'b0, e.reg_dst, e.alu_src, e.mem_write, e.mem_to_reg, e.reg_write, e.ext_op});
          check_eq("alu_ctr", {29'b0, alu_ctr}, {29'b0, e.alu});
          check_eq("npc_sel", {31'b0, npc_sel}, {31'b0, e.npc});
          check_eq("illegal", {31'b0, illegal}, {31'b0, e.illegal});
          $display("txn %0d instr=%08h rs=%0h rt=%0h imm=%08h rw=%0d alu=%0d npc=%0b ill=%0b",
                   n_consumed, out_instr, rs_data, rt_data, ext_imm, rw_addr, alu_ctr, npc_sel, illegal);
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(predict(instruction, rd_model(instruction[25:21]), rd_model(instruction[20:16])));
        n_sent++;
      end
      if (wb_en && wb_addr != 5'd0) mrf[wb_addr] = wb_data;
    end
  end

  // Random back-pressure and writeback traffic
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
      wb_en     = 1'($urandom_range(0, 1));
      wb_addr   = 5'($urandom_range(0, 7));
      wb_data   = $urandom_range(0, 3);
    end
  end

  // Present one instruction from posedge+1 and return at posedge+1 after acceptance
  task automatic send(input logic [31:0] ins);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    instruction = ins;
    for (int k = 0; k < 60 && !acc; k++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!acc) check_eq("accept_timeout", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
  endtask

  function automatic logic [31:0] gen_rand();
    logic [5:0] fn_tab [5];
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    int k;
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    k   = $urandom_range(0, 11);
    if (k < 5)  return {6'h00, rs, rt, rd, 5'b0, fn_tab[k]};
    if (k == 5) return {6'h0D, rs, rt, imm};
    if (k == 6) return {6'h23, rs, rt, imm};
    if (k == 7) return {6'h2B, rs, rt, imm};
    if (k < 10) return {6'h04, rs, rt, imm};
    if (k == 10) return {6'h00, rs, rt, rd, 5'b0, 6'h01};
    return {6'h3F, rs, rt, imm};
  endfunction

  initial begin
    int c0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;

    // Reset state
    #7;
    check_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check_eq("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check_eq("rst_out_instr", out_instr, TAG);
    check_eq("rst_rs_data", rs_data, 32'h0);
    check_eq("rst_ext_imm", ext_imm, 32'h0);
    check_eq("rst_ctrl", {25'b0, reg_write, mem_write, npc_sel, illegal, alu_ctr}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("rel_in_ready", {31'b0, in_ready}, 32'h1);

    // Directed: add, immediates, branches
    wb_write(5'd8, 32'd5);
    wb_write(5'd9, 32'd7);
    send(I_ADD);
    check_eq("tp_add_valid", {31'b0, out_valid}, 32'h1);
    check_eq("tp_add_rs", rs_data, 32'd5);
    check_eq("tp_add_rt", rt_data, 32'd7);
    check_eq("tp_add_rw", {27'b0, rw_addr}, 32'd10);
    check_eq("tp_add_alu", {29'b0, alu_ctr}, 32'd0);
    check_eq("tp_add_rw_en", {31'b0, reg_write}, 32'h1);
    send(I_ORI);
    check_eq("tp_ori_imm", ext_imm, 32'h0000_FFFF);
    check_eq("tp_ori_ext_op", {31'b0, ext_op}, 32'h0);
    send(I_LW);
    check_eq("tp_lw_imm", ext_imm, 32'hFFFF_FFFC);
    send(I_BEQ_EQ);
    check_eq("tp_beq_taken", {31'b0, npc_sel}, 32'h1);
    send(I_BEQ_NE);
    check_eq("tp_beq_not_taken", {31'b0, npc_sel}, 32'h0);

    // Back-to-back throughput
    c0 = cyc;
    send(I_SW); send(I_AND); send(I_OR); send(I_SLT);
    check_eq("throughput_cycles", cyc - c0, 32'd4);

    // Stall for 3 cycles with a pending instruction and a writeback to $8
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(I_ADD);
    in_valid = 1'b1; instruction = I_SUB;
    wb_en = 1'b1; wb_addr = 5'd8; wb_data = 32'd99;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("stall_in_ready", {31'b0, in_ready}, 32'h0);
      check_eq("stall_instr", out_instr, I_ADD);
      check_eq("stall_rs", rs_data, 32'd5);
      @(posedge clk); #1;
      wb_en = 1'b0;
    end
    out_ready = 1'b1;
    send(I_SUB);
    check_eq("post_stall_rt", rt_data, 32'd99);

    // Same-cycle writeback / read of $3
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA5;
    send(I_ADD_R3);
    wb_en = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
    check_eq("bypass_rs", rs_data, 32'hA5);
`else
    check_eq("bypass_rs", rs_data, 32'h0);
`endif
    send(I_ADD_R3);
    check_eq("after_wb_rs", rs_data, 32'hA5);

    // Writes to $0 are discarded, even with a same-cycle read
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    send(I_ADD_0_3);
    wb_en = 1'b0;
    check_eq("r0_same_cycle", rs_data, 32'h0);
    send(I_ADD_0_3);
    check_eq("r0_after", rs_data, 32'h0);

    // Illegal encodings
    send(I_BADOP);
    check_eq("ill_op", {29'b0, illegal, reg_write, mem_write}, 32'b100);
    send(I_BADFN);
    check_eq("ill_fn", {29'b0, illegal, reg_write, mem_write}, 32'b100);

    // Randomised traffic with back-pressure and writebacks
    @(posedge clk); #1;
    rand_mode = 1'b1;
    for (int n = 0; n < 30; n++) send(gen_rand());
    rand_mode = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1; wb_en = 1'b0;
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    #1;

    // Reset while stalled
    out_ready = 1'b0;
    send(I_ADD);
    in_valid = 1'b1; instruction = I_ORI;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    check_eq("midrst_in_ready", {31'b0, in_ready}, 32'h1);
    check_eq("midrst_out_instr", out_instr, TAG);
    check_eq("midrst_data", rs_data | rt_data | ext_imm | {27'b0, rw_addr}, 32'h0);
    check_eq("midrst_ctrl", {23'b0, reg_dst, alu_src, mem_write, mem_to_reg, reg_write, ext_op, npc_sel, illegal, alu_ctr[0]}, 32'h0);
    in_valid = 1'b0;
    sb_q.delete();
    n_sent = n_consumed;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(I_ADD);
    check_eq("post_rst_rs", rs_data, 32'h0);
    check_eq("post_rst_rt", rt_data, 32'h0);

    // Drain and verify nothing lost or duplicated
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check_eq("sb_empty", sb_q.size(), 32'h0);
    check_eq("sent_vs_consumed", n_consumed, n_sent);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage placed directly downstream of the instruction fetch unit. It accepts a 32-bit instruction word via a valid/ready handshake, reads operands from an internal 32×32 register file, and generates datapath control and a sign/zero-extended immediate. It resolves `beq` by comparing operands and returns `npc_sel` to fetch. A writeback port updates the register file.

## Interface
- `RESET_PC_TAG`, default 32'h0000_0000: value driven on `out_instr` while no valid instruction is held.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: fetch presents an instruction.
- `in_ready` output 1: stage can accept this cycle.
- `instruction` input 32: instruction word from fetch.
- `out_valid` output 1: decoded bundle valid.
- `out_ready` input 1: execute consumes the bundle.
- `out_instr` output 32: registered instruction.
- `rs_data`, `rt_data` output 32: operand values.
- `ext_imm` output 32: extended imm16.
- `rw_addr` output 5: destination register (rd if `reg_dst`, else rt).
- `reg_dst`, `alu_src`, `mem_write`, `mem_to_reg`, `reg_write`, `ext_op` output 1 each: control.
- `alu_ctr` output 3: 000 add, 001 sub, 010 and, 011 or, 100 slt.
- `npc_sel` output 1: branch taken, to fetch.
- `illegal` output 1: unsupported opcode/funct.
- `wb_en` input 1, `wb_addr` input 5, `wb_data` input 32: register-file write port.

## Operation
- Decoded opcodes: R-type (0x00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), ori 0x0D, lw 0x23, sw 0x2B, beq 0x04.
- `ext_op`=1 (sign-extend) for lw/sw/beq; 0 (zero-extend) for ori.
- R-type: `reg_dst`=1, `reg_write`=1, `alu_src`=0. ori: `alu_src`=1, `reg_write`=1, `alu_ctr`=or. lw: `alu_src`, `mem_to_reg`, `reg_write`. sw: `alu_src`, `mem_write`. beq: `alu_ctr`=sub, `npc_sel` = (rs_data == rt_data).
- Illegal opcode or funct: `illegal`=1, `reg_write`, `mem_write`, and `npc_sel` forced to 0, bundle still passed on.
- Register file: $0 reads as 0 and writes to it are discarded; write on posedge when `wb_en`.
- Handshake: one output register. `in_ready` = !`out_valid` || `out_ready`. On `in_valid`&&`in_ready`, capture and set `out_valid`. If `out_ready` and no new input, clear `out_valid`. While stalled (`out_valid` && !`out_ready`), all outputs hold.
- `npc_sel` is registered with the bundle and is qualified by `out_valid` (0 when not valid).

## Timing
- Latency: instruction accepted at edge N appears on outputs after edge N; throughput 1/cycle when `out_ready`=1.
- Operands are read from the register file at the acceptance edge.
- Same-cycle writeback and read of the same nonzero register: see Configuration.
- Reset (any time, including mid-stall): `out_valid`=0, all control outputs 0, `rs_data`/`rt_data`/`ext_imm`/`rw_addr`=0, `out_instr`=`RESET_PC_TAG`, all 32 registers 0. `in_ready`=1 during reset release.
- `wb_en` is honoured during stalls; a stalled bundle keeps its old operands and is not refreshed.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: a read of `wb_addr` (≠0) in the cycle `wb_en`=1 returns `wb_data`.
- Undefined: the read returns the pre-write value. The write itself is identical in both cases.

## Structure
- Package `decode_pkg`: opcode and funct constants, `alu_ctr` encodings, control-bundle field widths.
- Sub-module `reg_file_32`: 2 read ports, 1 write port, async reset, $0 hardwired, bypass under the macro.
- The top level contains the decoder, the beq comparator, and the handshake register.

## Test plan
- Reset, then write $8=5 and $9=7. Send `add $10,$8,$9` (0x0109_5020) → `out_valid`=1 next cycle, `rs_data`=5, `rt_data`=7, `rw_addr`=10, `alu_ctr`=000, `reg_write`=1.
- `ori $4,$0,0xFFFF` → `ext_imm`=0x0000_FFFF, `ext_op`=0. `lw $4,-4($2)` → `ext_imm`=0xFFFF_FFFC.
- `beq $8,$8,+3` → `npc_sel`=1. `beq $8,$9` with 5≠7 → `npc_sel`=0.
- `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable. Release → the next instruction is accepted and none is lost or duplicated.
- `wb_en` to $3=0xA5 in the same cycle `add` reads $3 → `rs_data`=0xA5 with the macro, 0 without it. Write to $0 → reads 0.
- Opcode 0x3F → `illegal`=1, `reg_write`/`mem_write`=0. Assert `rst_n`=0 mid-stall → `out_valid` drops immediately.
